// File: rtl/dct32_odd_mac.sv
// Serial odd-part accumulator for the 32-point DCT-II, plus its shift-add SAU.
// Ports: clk/rst, in_valid/in_ready/in_data, out_valid/out_ready/out_idx/out_data.

module sau_16o (
  input  logic [16:0] x,
  output logic [26:0] x90,
  output logic [26:0] x88,
  output logic [26:0] x85,
  output logic [26:0] x82,
  output logic [26:0] x78,
  output logic [26:0] x73,
  output logic [26:0] x67,
  output logic [26:0] x61,
  output logic [26:0] x54,
  output logic [26:0] x46,
  output logic [26:0] x38,
  output logic [26:0] x31,
  output logic [26:0] x22,
  output logic [26:0] x13,
  output logic [26:0] x4
);
  logic signed [26:0] e;
  assign e = {{10{x[16]}}, x};

  assign x90 = (e <<< 6) + (e <<< 4) + (e <<< 3) + (e <<< 1);
  assign x88 = (e <<< 6) + (e <<< 4) + (e <<< 3);
  assign x85 = (e <<< 6) + (e <<< 4) + (e <<< 2) + e;
  assign x82 = (e <<< 6) + (e <<< 4) + (e <<< 1);
  assign x78 = (e <<< 6) + (e <<< 3) + (e <<< 2) + (e <<< 1);
  assign x73 = (e <<< 6) + (e <<< 3) + e;
  assign x67 = (e <<< 6) + (e <<< 1) + e;
  assign x61 = (e <<< 6) - (e <<< 1) - e;
  assign x54 = (e <<< 5) + (e <<< 4) + (e <<< 2) + (e <<< 1);
  assign x46 = (e <<< 5) + (e <<< 3) + (e <<< 2) + (e <<< 1);
  assign x38 = (e <<< 5) + (e <<< 2) + (e <<< 1);
  assign x31 = (e <<< 5) - e;
  assign x22 = (e <<< 4) + (e <<< 2) + (e <<< 1);
  assign x13 = (e <<< 3) + (e <<< 2) + e;
  assign x4  = e <<< 2;
endmodule

module dct32_odd_mac #(
  parameter int OUT_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_idx,
  output logic [30:0] out_data
);

  // Per (row, sample) entry: {negate, SAU product index}; built at
  // elaboration so the datapath only sees 16 muxes keyed by the counter.
  function automatic logic [1279:0] build_tab();
    logic [1279:0] t;
    int m;
    t = '0;
    for (int r = 0; r < 16; r++) begin
      for (int n = 0; n < 16; n++) begin
        m = ((2 * n + 1) * (2 * r + 1)) % 128;
        if (m >= 64) m = 128 - m;
        if (m < 32)
          t[(r * 16 + n) * 5 +: 5] = {1'b0, 4'((m - 1) / 2)};
        else
          t[(r * 16 + n) * 5 +: 5] = {1'b1, 4'((63 - m) / 2)};
      end
    end
    return t;
  endfunction

  localparam logic [1279:0] SEL_TAB = build_tab();

  typedef enum logic {ACC, DRAIN} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic signed [30:0] acc  [16];
  logic signed [30:0] nxt  [16];
  logic [26:0]        prod [16];
  logic [4:0]         sel  [16];
  logic signed [30:0] term [16];
  logic signed [30:0] base [16];

  sau_16o u_sau (
    .x   (in_data),
    .x90 (prod[0]),
    .x88 (prod[2]),
    .x85 (prod[3]),
    .x82 (prod[4]),
    .x78 (prod[5]),
    .x73 (prod[6]),
    .x67 (prod[7]),
    .x61 (prod[8]),
    .x54 (prod[9]),
    .x46 (prod[10]),
    .x38 (prod[11]),
    .x31 (prod[12]),
    .x22 (prod[13]),
    .x13 (prod[14]),
    .x4  (prod[15])
  );

  // C(1) and C(3) are both 90
  assign prod[1] = prod[0];

  always_comb begin
    for (int r = 0; r < 16; r++) begin
      sel[r]  = SEL_TAB[(r * 16 + int'(cnt)) * 5 +: 5];
      term[r] = {{4{prod[sel[r][3:0]][26]}}, prod[sel[r][3:0]]};
      base[r] = (cnt == 4'd0) ? '0 : acc[r];
      nxt[r]  = sel[r][4] ? base[r] - term[r] : base[r] + term[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACC;
      cnt     <= '0;
      out_idx <= '0;
      for (int r = 0; r < 16; r++) acc[r] <= '0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            for (int r = 0; r < 16; r++) acc[r] <= nxt[r];
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_idx <= out_idx + 4'd1;
            if (out_idx == 4'd15) state <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DRAIN);

  logic signed [30:0] cur;
  assign cur = acc[out_idx];

  generate
    if (OUT_SHIFT == 0) begin : g_noshift
      assign out_data = cur;
    end else begin : g_shift
      localparam logic signed [30:0] RND = 31'sd1 <<< (OUT_SHIFT - 1);
      logic signed [30:0] sum;
      assign sum      = cur + RND;
      assign out_data = sum >>> OUT_SHIFT;
    end
  endgenerate

endmodule

// File: tb/tb_dct32_odd_mac.sv
// Bench for dct32_odd_mac: two instances (OUT_SHIFT 0 and 5) on one stream,
// checked against a cosine-table reference model.

module tb_dct32_odd_mac;

  typedef logic signed [16:0] blk_t [16];
  typedef longint res_t [16];

  localparam int CT[16] = '{90, 90, 88, 85, 82, 78, 73, 67,
                            61, 54, 46, 38, 31, 22, 13, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [16:0] in_data;
  logic        out_ready;
  logic        in_ready0, out_valid0, in_ready5, out_valid5;
  logic [3:0]  out_idx0, out_idx5;
  logic [30:0] out_data0, out_data5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dct32_odd_mac #(.OUT_SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_idx(out_idx0), .out_data(out_data0)
  );

  dct32_odd_mac #(.OUT_SHIFT(5)) u5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
    .in_data(in_data), .out_valid(out_valid5), .out_ready(out_ready),
    .out_idx(out_idx5), .out_data(out_data5)
  );

  task automatic check(input string tag, input longint obs,
                       input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int coef(int r, int n);
    int m;
    m = ((2 * n + 1) * (2 * r + 1)) % 128;
    if (m >= 64) m = 128 - m;
    if (m < 32) return CT[(m - 1) / 2];
    return -CT[(64 - m - 1) / 2];
  endfunction

  // floor((v + 16) / 32) done with truncating division
  function automatic longint rnd5(longint v);
    longint t, q;
    t = v + 16;
    q = t / 32;
    if ((t % 32 != 0) && (t < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model(input blk_t s, output res_t e0,
                                output res_t e5);
    for (int r = 0; r < 16; r++) begin
      e0[r] = 0;
      for (int n = 0; n < 16; n++)
        e0[r] += longint'(s[n]) * longint'(coef(r, n));
      e5[r] = rnd5(e0[r]);
    end
  endfunction

  task automatic send(input blk_t s, input bit bub, input int nsamp);
    int n = 0;
    int cyc = 0;
    while (n < nsamp && cyc < 400) begin
      @(negedge clk);
      if (bub && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = s[n];
      end
      if (in_valid && in_ready0) n++;
      cyc++;
    end
    if (n < nsamp) check("send_timeout", n, nsamp);
    @(negedge clk);
    in_valid = 1'b0;
    if (nsamp == 16) begin
      check("lat_out_valid", out_valid0, 1);
      check("lat_out_idx", out_idx0, 0);
      check("lat_in_ready", in_ready0, 0);
    end
  endtask

  task automatic drain(input res_t e0, input res_t e5,
                       input int stall_at, input int stop_after);
    int idx = 0;
    int cyc = 0;
    int st = 0;
    while (idx < stop_after && cyc < 400) begin
      check("out_valid", out_valid0, 1);
      check("out_valid5", out_valid5, 1);
      check("out_idx", out_idx0, idx);
      check("data_s0", longint'($signed(out_data0)), e0[idx]);
      check("data_s5", longint'($signed(out_data5)), e5[idx]);
      if (idx == stall_at && st < 5) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 17'($urandom_range(0, 131071));
        check("stall_in_ready", in_ready0, 0);
        st++;
      end else begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    if (idx < stop_after) check("drain_timeout", idx, stop_after);
    if (stop_after == 16) begin
      check("back_in_ready", in_ready0, 1);
      check("back_out_valid", out_valid0, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready0, 1);
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_idx", out_idx0, 0);
    check("rst_out_data", out_data0, 0);
    check("rst_out_data5", out_data5, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    blk_t b;
    res_t e0, e5;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    do_reset();

    b = '{default: '0};
    b[0] = 17'sd1;
    model(b, e0, e5);
    check("impulse_r0_model", e0[0], 90);
    check("impulse_r15_model", e0[15], 4);
    send(b, 1'b0, 16);
    drain(e0, e5, -1, 16);

    b = '{default: 17'sd1};
    model(b, e0, e5);
    check("dc_r0_model", e0[0], 922);
    check("dc_r1_model", e0[1], -308);
    send(b, 1'b0, 16);
    drain(e0, e5, -1, 16);

    b = '{default: -17'sd65536};
    model(b, e0, e5);
    check("dcneg_r0_model", e0[0], -60424192);
    send(b, 1'b0, 16);
    drain(e0, e5, -1, 16);

    for (int n = 0; n < 16; n++) b[n] = 17'($urandom_range(0, 131071));
    model(b, e0, e5);
    send(b, 1'b0, 16);
    drain(e0, e5, 3, 16);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 16; n++) b[n] = 17'($urandom_range(0, 131071));
      model(b, e0, e5);
      send(b, 1'b1, 16);
      drain(e0, e5, -1, 16);
    end

    for (int n = 0; n < 16; n++) b[n] = 17'($urandom_range(0, 131071));
    send(b, 1'b0, 7);
    do_reset();
    b = '{default: '0};
    b[0] = 17'sd1;
    model(b, e0, e5);
    send(b, 1'b0, 16);
    drain(e0, e5, -1, 16);

    for (int n = 0; n < 16; n++) b[n] = 17'($urandom_range(0, 131071));
    model(b, e0, e5);
    send(b, 1'b0, 16);
    drain(e0, e5, -1, 3);
    do_reset();

    b = '{default: '0};
    b[0] = 17'sd1000;
    model(b, e0, e5);
    check("sh5_pos_model", e5[0], 2813);
    send(b, 1'b0, 16);
    drain(e0, e5, -1, 16);

    b[0] = -17'sd1000;
    model(b, e0, e5);
    check("sh5_neg_model", e5[0], -2812);
    send(b, 1'b1, 16);
    drain(e0, e5, -1, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dct32_odd_mac.md
# dct32_odd_mac

Serial odd-part accumulator for the 32-point DCT-II, sitting directly downstream of the shared shift-add multiplier unit `sau_16o` and instantiating one copy of it. It accepts the 16 odd-part butterfly differences O[n] = e[n] − e[31−n] one per handshake. Each sample is multiplied by all 16 odd-row coefficients through the SAU outputs, and the products are accumulated into 16 row accumulators. Once a block is complete, the block streams the 16 odd-index DCT outputs (rows k = 1, 3, …, 31) out one per handshake.

## Interface
- `OUT_SHIFT`, default 0, rounding right-shift applied to each result on output (0..16).
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_data` holds sample O[n].
- `in_ready`  out  1  block is accepting samples.
- `in_data`  in  17  signed odd-part sample, drives the SAU `X` input.
- `out_valid`  out  1  `out_data` holds the result for row `out_idx`.
- `out_ready`  in  1  consumer accepts the result.
- `out_idx`  out  4  result index r; the DCT row is k = 2r+1.
- `out_data`  out  31  signed result, sign-extended after the shift.

## Operation
- Coefficient table C(j) for odd j in 1..31: 90,90,88,85,82,78,73,67,61,54,46,38,31,22,13,4. These map to SAU outputs x90 (used twice), x88, …, x4.
- Coefficient for row r, sample n:
  - m = ((2n+1)(2r+1)) mod 128.
  - Fold: m' = m if m<64, else 128−m.
  - If m'<32, coef = +C(m'). Otherwise coef = −C(64−m').
- Sign is applied by add or subtract in the accumulator. The block contains no multipliers beyond the SAU; selection is by 16 muxes indexed from (r, n).
- Accumulate on accepted sample n: acc[r] <= (n==0 ? 0 : acc[r]) ± sel(r,n), for all 16 r in the same cycle.
- Width rules:
  - 27-bit SAU products are sign-extended to 31-bit accumulators.
  - Maximum magnitude is 16·90·65536 < 2^30, so no overflow and no saturation logic.
- Output:
  - With `OUT_SHIFT`=0, `out_data` = acc[out_idx].
  - Otherwise, `out_data` = (acc[out_idx] + 2^(OUT_SHIFT−1)) >>> OUT_SHIFT. This is 31-bit arithmetic with ties rounded toward +∞.
- State machine, 2 states:
  - ACC: `in_ready`=1 and 4-bit sample counter n. An accepted sample increments n. Accepting n=15 transitions to DRAIN and sets n to 0.
  - DRAIN: `in_ready`=0, `out_valid`=1. `out_valid`&&`out_ready` increments `out_idx`. The handshake at `out_idx`=15 returns to ACC with `out_idx` set to 0.
- `in_valid` in DRAIN is ignored and no sample is consumed.
- Reset, whether idle or mid-block: state ACC, n=0, `out_idx`=0, all acc=0. A partial block is discarded. The next accepted sample is treated as n=0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_idx`=0, `out_data`=0.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready`.
- `out_data` is a combinational mux of registered accumulators. It is stable while `out_valid`=1 and `out_ready`=0.
- Latency: sample 15 accepted at edge t gives `out_valid`=1 with `out_idx`=0 in the cycle after t.
- Output of the last result accepted at edge t gives `in_ready`=1 in the cycle after t.
- Peak throughput is 32 cycles per block: 16 in, 16 out. Input bubbles and output backpressure stall only the current phase.
- The SAU is purely combinational in the same cycle. The accumulator update is the only register stage on the datapath.

## Test plan
- Impulse: O[0]=1, O[1..15]=0, `OUT_SHIFT`=0 -> r=0..15 gives 90,90,88,85,82,78,73,67,61,54,46,38,31,22,13,4.
- DC block: all O[n]=1 -> r=0 gives 922, r=1 gives −308. The same block with all O[n]=−65536 gives r=0 = −60424192 with no overflow.
- Backpressure: hold `out_ready`=0 for 5 cycles at `out_idx`=3 while `in_valid`=1 -> `out_idx` and `out_data` are stable, `in_ready`=0, and no sample is consumed. Resume and verify all 16 results are in order.
- Input bubbles: toggle `in_valid` randomly -> results match the zero-bubble golden model. `out_valid` rises exactly 1 cycle after the 16th accepted sample.
- Reset mid-block: assert `rst` after 7 samples, then feed the impulse block -> exactly the impulse results. Also assert `rst` during DRAIN -> `out_valid`=0 and `in_ready`=1 immediately.
- `OUT_SHIFT`=5: O[0]=1000, others 0 -> r=0 gives 2813. O[0]=−1000 -> r=0 gives −2812.
